// File: rtl/ram_pkg.sv
// Shared types and byte helpers for ram_sdp_clr (state enum, byte merge, byte parity).
// Latency: none; types and pure functions only.
// Backpressure: none.
package ram_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    // Pick the new byte where its enable is set, else keep the old one.
    function automatic logic [BYTE_W-1:0] byte_merge(
        input logic [BYTE_W-1:0] old_b,
        input logic [BYTE_W-1:0] new_b,
        input logic              be
    );
        return be ? new_b : old_b;
    endfunction

    // Even parity bit: makes the total count of ones in byte+parity even.
    function automatic logic byte_par(input logic [BYTE_W-1:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/ram_sdp_clr_if.sv
// Write/read/clear bus of ram_sdp_clr; master drives strobes, slave is the RAM.
// Latency: none; wiring only. RAM_SDP_PARITY_EN adds inj_err and par_err.
// Backpressure: none at this level; busy tells the master that strobes are dropped.
interface ram_sdp_clr_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) ();
    logic                    clr_req;
    logic                    busy;
    logic                    wr_en;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic [DATA_WIDTH/8-1:0] wr_be;
    logic                    rd_en;
    logic [ADDR_WIDTH-1:0]   rd_addr;
    logic [DATA_WIDTH-1:0]   rd_data;
    logic                    rd_valid;
`ifdef RAM_SDP_PARITY_EN
    logic                    inj_err;
    logic                    par_err;

    modport master (output clr_req, wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr, inj_err,
                    input  busy, rd_data, rd_valid, par_err);
    modport slave  (input  clr_req, wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr, inj_err,
                    output busy, rd_data, rd_valid, par_err);
`else
    modport master (output clr_req, wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
                    input  busy, rd_data, rd_valid);
    modport slave  (input  clr_req, wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
                    output busy, rd_data, rd_valid);
`endif
endinterface

// File: rtl/ram_sdp_array.sv
// Raw storage: lane-masked synchronous write port and registered read port, no control.
// Latency: read data registered on the edge that samples re (1 cycle); same-edge write is not visible.
// Backpressure: none; every strobe is accepted.
module ram_sdp_array #(
    parameter int ADDR_WIDTH = 8,
    parameter int NB         = 1,
    parameter int LANE_W     = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       we,
    input  logic [ADDR_WIDTH-1:0]      waddr,
    input  logic [NB-1:0][LANE_W-1:0]  wdata,
    input  logic [NB-1:0]              wlane,
    input  logic                       re,
    input  logic [ADDR_WIDTH-1:0]      raddr,
    output logic [NB-1:0][LANE_W-1:0]  rdata
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [NB-1:0][LANE_W-1:0] mem [DEPTH];

    // Lane-masked write; the array itself is never reset.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int k = 0; k < NB; k++) begin
                if (wlane[k]) mem[waddr][k] <= wdata[k];
            end
        end
    end

    // Registered read returns the pre-write word on an address collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/ram_sdp_clr.sv
// Simple dual-port RAM with byte enables, read-during-write select and a clear sequencer (RAM_SDP_PARITY_EN adds byte parity).
// Latency: read data 1 cycle after rd_en (OUT_REG=0) or 2 cycles (OUT_REG=1); full throughput.
// Backpressure: none; while busy (clearing) wr_en/rd_en/clr_req are dropped, not queued.
module ram_sdp_clr
    import ram_pkg::*;
#(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ADDR_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
    parameter int                    RDW_NEW    = 0,
    parameter int                    OUT_REG    = 0
) (
    input logic          clk,
    input logic          rst_n,
    ram_sdp_clr_if.slave bus
);
    localparam int NB = DATA_WIDTH / BYTE_W;
`ifdef RAM_SDP_PARITY_EN
    localparam int LANE_W = BYTE_W + 1;
`else
    localparam int LANE_W = BYTE_W;
`endif

    state_t                    state, state_nxt;
    logic [ADDR_WIDTH-1:0]     ptr;
    logic                      busy, usr_wr, usr_rd;

    logic [NB-1:0][LANE_W-1:0] usr_lane, init_lane, arr_wdata, arr_rdata;
    logic                      arr_we;
    logic [ADDR_WIDTH-1:0]     arr_waddr;
    logic [NB-1:0]             arr_wlane;

    logic                      rd_v0, byp;
    logic [NB-1:0]             byp_be;
    logic [NB-1:0][LANE_W-1:0] byp_dat;
    logic [DATA_WIDTH-1:0]     word0;
`ifdef RAM_SDP_PARITY_EN
    logic [NB-1:0]             err0;
`endif

    // State register: reset always restarts the clear from address 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= CLEAR;
        else        state <= state_nxt;
    end

    // Next state: leave CLEAR after the last address, enter it on a request while idle.
    always_comb begin
        state_nxt = state;
        case (state)
            CLEAR:   if (ptr == '1)  state_nxt = IDLE;
            IDLE:    if (bus.clr_req) state_nxt = CLEAR;
            default: state_nxt = CLEAR;
        endcase
    end

    // Outputs of the FSM: user strobes only pass while idle.
    always_comb begin
        busy   = (state == CLEAR);
        usr_wr = bus.wr_en & ~busy;
        usr_rd = bus.rd_en & ~busy;
    end

    assign bus.busy = busy;

    // Clear pointer walks every address once per clear, parks at 0 while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              ptr <= '0;
        else if (state == CLEAR) ptr <= ptr + 1'b1;
        else                     ptr <= '0;
    end

    // Per-byte lane formation for user data, clear data and the read merge.
    for (genvar k = 0; k < NB; k++) begin : g_lane
        localparam logic [BYTE_W-1:0] INIT_B = INIT_VALUE[k*BYTE_W +: BYTE_W];
        logic take;
        assign take = byp & byp_be[k];
        assign word0[k*BYTE_W +: BYTE_W] =
            byte_merge(arr_rdata[k][BYTE_W-1:0], byp_dat[k][BYTE_W-1:0], take);
`ifdef RAM_SDP_PARITY_EN
        logic par_b;
        // Byte 0 parity can be flipped on purpose to exercise the checker.
        assign usr_lane[k]  = {byte_par(bus.wr_data[k*BYTE_W +: BYTE_W]) ^ ((k == 0) ? bus.inj_err : 1'b0),
                               bus.wr_data[k*BYTE_W +: BYTE_W]};
        assign init_lane[k] = {byte_par(INIT_B), INIT_B};
        assign par_b        = take ? byp_dat[k][BYTE_W] : arr_rdata[k][BYTE_W];
        assign err0[k]      = par_b ^ byte_par(word0[k*BYTE_W +: BYTE_W]);
`else
        assign usr_lane[k]  = bus.wr_data[k*BYTE_W +: BYTE_W];
        assign init_lane[k] = INIT_B;
`endif
    end

    // Write mux: the clear sequencer owns the write port while busy.
    always_comb begin
        arr_we    = usr_wr;
        arr_waddr = bus.wr_addr;
        arr_wdata = usr_lane;
        arr_wlane = bus.wr_be;
        if (busy) begin
            arr_we    = 1'b1;
            arr_waddr = ptr;
            arr_wdata = init_lane;
            arr_wlane = '1;
        end
    end

    ram_sdp_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NB         (NB),
        .LANE_W     (LANE_W)
    ) u_array (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (arr_we),
        .waddr (arr_waddr),
        .wdata (arr_wdata),
        .wlane (arr_wlane),
        .re    (usr_rd),
        .raddr (bus.rd_addr),
        .rdata (arr_rdata)
    );

    // Capture the colliding write alongside an accepted read so new-data mode can overlay it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_v0   <= 1'b0;
            byp     <= 1'b0;
            byp_be  <= '0;
            byp_dat <= '0;
        end else begin
            rd_v0 <= usr_rd;
            if (usr_rd) begin
                byp     <= (RDW_NEW != 0) && usr_wr && (bus.wr_addr == bus.rd_addr);
                byp_be  <= bus.wr_be;
                byp_dat <= usr_lane;
            end
        end
    end

    if (OUT_REG != 0) begin : g_oreg
        logic [DATA_WIDTH-1:0] rd_data_q;
        logic                  rd_valid_q;
`ifdef RAM_SDP_PARITY_EN
        logic                  par_err_q;
        // Parity flag registered with the data it describes.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) par_err_q <= 1'b0;
            else        par_err_q <= rd_v0 & (|err0);
        end
        assign bus.par_err = par_err_q;
`endif
        // Output register; data holds when no read completes.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_data_q  <= '0;
                rd_valid_q <= 1'b0;
            end else begin
                rd_valid_q <= rd_v0;
                if (rd_v0) rd_data_q <= word0;
            end
        end
        assign bus.rd_data  = rd_data_q;
        assign bus.rd_valid = rd_valid_q;
    end else begin : g_comb
        assign bus.rd_data  = word0;
        assign bus.rd_valid = rd_v0;
`ifdef RAM_SDP_PARITY_EN
        assign bus.par_err  = rd_v0 & (|err0);
`endif
    end

endmodule

// File: tb/tb_ram_sdp_clr.sv
// Scoreboard bench for ram_sdp_clr: two instances (old-data/no out reg, new-data/out reg) share stimulus.
// Latency: expected responses carry the cycle they are due in.
// Backpressure: model drops strobes while the clear runs, like the design.
module tb_ram_sdp_clr;
    localparam int          DEPTH = 256;
    localparam logic [15:0] INIT0 = 16'hC3A5;
    localparam logic [15:0] INIT1 = 16'h5A0F;

    typedef struct {
        logic [15:0] dat;
        logic        par;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        clr_req = 1'b0, wr_en = 1'b0, rd_en = 1'b0, inj_err = 1'b0;
    logic [7:0]  wr_addr = '0, rd_addr = '0;
    logic [15:0] wr_data = '0;
    logic [1:0]  wr_be = '0;

    int cyc = 0, nchk = 0, nerr = 0, busy_left = DEPTH;

    logic [15:0] mem0 [DEPTH];
    logic [15:0] mem1 [DEPTH];
    bit          bad0 [DEPTH];
    bit          bad1 [DEPTH];
    exp_t        q0[$];
    exp_t        q1[$];

    ram_sdp_clr_if #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) if0 ();
    ram_sdp_clr_if #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) if1 ();

    assign if0.clr_req = clr_req;  assign if1.clr_req = clr_req;
    assign if0.wr_en   = wr_en;    assign if1.wr_en   = wr_en;
    assign if0.wr_addr = wr_addr;  assign if1.wr_addr = wr_addr;
    assign if0.wr_data = wr_data;  assign if1.wr_data = wr_data;
    assign if0.wr_be   = wr_be;    assign if1.wr_be   = wr_be;
    assign if0.rd_en   = rd_en;    assign if1.rd_en   = rd_en;
    assign if0.rd_addr = rd_addr;  assign if1.rd_addr = rd_addr;

    logic p0, p1;
`ifdef RAM_SDP_PARITY_EN
    assign if0.inj_err = inj_err;  assign if1.inj_err = inj_err;
    assign p0 = if0.par_err;
    assign p1 = if1.par_err;
`else
    assign p0 = 1'b0;
    assign p1 = 1'b0;
`endif

    ram_sdp_clr #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .INIT_VALUE(INIT0), .RDW_NEW(0), .OUT_REG(0))
        u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    ram_sdp_clr #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .INIT_VALUE(INIT1), .RDW_NEW(1), .OUT_REG(1))
        u1 (.clk(clk), .rst_n(rst_n), .bus(if1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (!ok) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] merge(input logic [15:0] o, input logic [15:0] n, input logic [1:0] be);
        logic [15:0] m;
        m = {{8{be[1]}}, {8{be[0]}}};
        return (o & ~m) | (n & m);
    endfunction

    task automatic fill();
        for (int a = 0; a < DEPTH; a++) begin
            mem0[a] = INIT0; mem1[a] = INIT1;
            bad0[a] = 1'b0;  bad1[a] = 1'b0;
        end
    endtask

    // Reference: effect of the inputs currently driven, at the coming clock edge.
    task automatic model_edge();
        exp_t e;
        if (busy_left > 0) begin
            busy_left--;
            return;
        end
        if (rd_en) begin
            e.dat = mem0[rd_addr]; e.par = bad0[rd_addr]; e.due = cyc + 1;
            q0.push_back(e);
            e.dat = mem1[rd_addr]; e.par = bad1[rd_addr]; e.due = cyc + 2;
            if (wr_en && wr_addr == rd_addr) begin
                e.dat = merge(e.dat, wr_data, wr_be);
                if (wr_be[0]) e.par = inj_err;
            end
            q1.push_back(e);
        end
        if (wr_en) begin
            mem0[wr_addr] = merge(mem0[wr_addr], wr_data, wr_be);
            mem1[wr_addr] = merge(mem1[wr_addr], wr_data, wr_be);
            if (wr_be[0]) begin
                bad0[wr_addr] = inj_err;
                bad1[wr_addr] = inj_err;
            end
        end
        if (clr_req) begin
            busy_left = DEPTH;
            fill();
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        chk(if0.busy == (busy_left > 0), "busy_u0", 32'(if0.busy), 32'(busy_left > 0));
        chk(if1.busy == (busy_left > 0), "busy_u1", 32'(if1.busy), 32'(busy_left > 0));
    endtask

    task automatic op(input bit clr, input bit we, input logic [7:0] wa, input logic [15:0] wd,
                      input logic [1:0] be, input bit re, input logic [7:0] ra, input bit inj);
        clr_req = clr; wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be;
        rd_en = re; rd_addr = ra; inj_err = inj;
        tick();
        clr_req = 1'b0; wr_en = 1'b0; rd_en = 1'b0; inj_err = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [15:0] d, input logic [1:0] be);
        op(1'b0, 1'b1, a, d, be, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic rd(input logic [7:0] a);
        op(1'b0, 1'b0, 8'h00, 16'h0000, 2'b00, 1'b1, a, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) op(1'b0, 1'b0, 8'h00, 16'h0000, 2'b00, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic wait_clear();
        while (busy_left > 0) idle(1);
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        q0.delete();
        q1.delete();
        busy_left = DEPTH;
        fill();
        repeat (n) @(posedge clk);
        #1;
        chk(if0.busy == 1'b1,       "reset_busy_u0",  32'(if0.busy),     32'd1);
        chk(if1.busy == 1'b1,       "reset_busy_u1",  32'(if1.busy),     32'd1);
        chk(if0.rd_valid == 1'b0,   "reset_vld_u0",   32'(if0.rd_valid), 32'd0);
        chk(if1.rd_valid == 1'b0,   "reset_vld_u1",   32'(if1.rd_valid), 32'd0);
        chk(if0.rd_data == 16'h0,   "reset_data_u0",  32'(if0.rd_data),  32'd0);
        chk(if1.rd_data == 16'h0,   "reset_data_u1",  32'(if1.rd_data),  32'd0);
        chk(p0 == 1'b0,             "reset_par_u0",   32'(p0),           32'd0);
        rst_n = 1'b1;
    endtask

    // Monitor side of the scoreboard: one pop per presented read.
    task automatic mon(input int i, input logic vld, input logic [15:0] dat, input logic par);
        exp_t e;
        int   n;
        n = (i == 0) ? q0.size() : q1.size();
        if (vld) begin
            if (n == 0) begin
                chk(1'b0, (i == 0) ? "spurious_vld_u0" : "spurious_vld_u1", 32'd1, 32'd0);
            end else begin
                if (i == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                chk(dat == e.dat, (i == 0) ? "rd_data_u0" : "rd_data_u1", 32'(dat), 32'(e.dat));
                chk(cyc == e.due, (i == 0) ? "rd_cycle_u0" : "rd_cycle_u1", 32'(cyc), 32'(e.due));
`ifdef RAM_SDP_PARITY_EN
                chk(par == e.par, (i == 0) ? "par_err_u0" : "par_err_u1", 32'(par), 32'(e.par));
`endif
            end
        end else if (n > 0) begin
            if (i == 0) e = q0[0];
            else        e = q1[0];
            if (e.due < cyc) begin
                chk(1'b0, (i == 0) ? "missing_vld_u0" : "missing_vld_u1", 32'(cyc), 32'(e.due));
                if (i == 0) void'(q0.pop_front());
                else        void'(q1.pop_front());
            end
        end
`ifndef RAM_SDP_PARITY_EN
        if (par) chk(1'b0, "par_tied", 32'(par), 32'd0);
`endif
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            mon(0, if0.rd_valid, if0.rd_data, p0);
            mon(1, if1.rd_valid, if1.rd_data, p1);
        end
    end

    initial begin
        #2;
        do_reset(3);

        // Initial clear, then a read of a never-written word.
        wait_clear();
        rd(8'h34);
        idle(3);

        // Byte-enable partial overwrite.
        wr(8'h10, 16'hBEEF, 2'b11);
        wr(8'h10, 16'h1234, 2'b01);
        rd(8'h10);
        idle(3);

        // Same-address read and write in one cycle.
        wr(8'h20, 16'h5555, 2'b11);
        op(1'b0, 1'b1, 8'h20, 16'hAAAA, 2'b11, 1'b1, 8'h20, 1'b0);
        idle(3);

        // Fill 0x00-0x0F, clear, hammer strobes while busy, read back.
        for (int a = 0; a < 16; a++) wr(8'(a), 16'($urandom), 2'b11);
        op(1'b1, 1'b0, 8'h00, 16'h0000, 2'b00, 1'b0, 8'h00, 1'b0);
        while (busy_left > 0)
            op(1'($urandom_range(0, 1)), 1'b1, 8'($urandom_range(0, 15)), 16'($urandom), 2'b11,
               1'b1, 8'($urandom_range(0, 15)), 1'b0);
        for (int a = 0; a < 16; a++) rd(8'(a));
        idle(3);

        // Reset in the middle of a clear restarts the full sequence.
        op(1'b1, 1'b0, 8'h00, 16'h0000, 2'b00, 1'b0, 8'h00, 1'b0);
        idle(100);
        do_reset(2);
        wait_clear();

        // Back-to-back reads at full throughput.
        for (int k = 0; k < 4; k++) wr(8'(8'h50 + k), 16'(16'h1100 * (k + 1)), 2'b11);
        for (int k = 0; k < 4; k++) rd(8'(8'h50 + k));
        idle(4);

        // Read in flight when a clear is accepted still completes.
        wr(8'h60, 16'h6E6E, 2'b11);
        op(1'b1, 1'b0, 8'h00, 16'h0000, 2'b00, 1'b1, 8'h60, 1'b0);
        wait_clear();

`ifdef RAM_SDP_PARITY_EN
        // Injected byte-0 parity fault, then a clean rewrite.
        op(1'b0, 1'b1, 8'h40, 16'h00FF, 2'b11, 1'b0, 8'h00, 1'b1);
        rd(8'h40);
        wr(8'h40, 16'h00FF, 2'b11);
        rd(8'h40);
        idle(3);
`endif

        // Random traffic, addresses mostly in a small window to force collisions.
        repeat (3000) begin
            bit inj;
            inj = 1'b0;
`ifdef RAM_SDP_PARITY_EN
            inj = ($urandom_range(0, 7) == 0);
`endif
            op(($urandom_range(0, 399) == 0), 1'($urandom),
               ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15)),
               16'($urandom), 2'($urandom), 1'($urandom),
               ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15)), inj);
        end
        wait_clear();
        idle(5);

        chk(q0.size() == 0, "drain_u0", 32'(q0.size()), 32'd0);
        chk(q1.size() == 0, "drain_u1", 32'(q1.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
